// File: rtl/fifo_word_packer.sv
// Packs RATIO_P consecutive words popped from a valid-yumi FIFO into one wide
// valid-ready packet; a flush request emits a partial packet with a lane mask.
module fifo_word_packer #(
    parameter int WIDTH_P = 8,
    parameter int RATIO_P = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [WIDTH_P-1:0]         data_i,
    output logic                       yumi_o,
    input  logic                       flush_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH_P*RATIO_P-1:0] data_o,
    output logic [RATIO_P-1:0]         mask_o
);

    localparam int CW = (RATIO_P > 1) ? $clog2(RATIO_P) : 1;
    localparam int FW = $clog2(RATIO_P + 1);

    logic [CW-1:0]                count_r;
    logic [WIDTH_P*RATIO_P-1:0]   lanes_r;
    logic [WIDTH_P*RATIO_P-1:0]   lanes_n;
    logic                         flush_pending_r;

    logic                         out_free;
    logic                         last_lane;
    logic                         accept;
    logic                         flush_req;
    logic                         full_xfer;
    logic                         flush_xfer;
    logic                         load;
    logic [FW-1:0]                fill;
    logic [RATIO_P-1:0]           fill_mask;

    assign out_free  = ~valid_o | ready_i;
    assign last_lane = (count_r == CW'(RATIO_P - 1));

    // A pending flush freezes the partial packet until the output register frees up.
    assign yumi_o = valid_i & ~reset_i & (~last_lane | out_free)
                  & (~flush_pending_r | out_free);
    assign accept = yumi_o;

    assign flush_req  = flush_pending_r | flush_i;
    assign fill       = FW'(count_r) + FW'(accept);
    assign full_xfer  = accept & last_lane;
    assign flush_xfer = flush_req & out_free & (fill != '0) & ~full_xfer;
    assign load       = full_xfer | flush_xfer;

    // Accumulator view including the word accepted this cycle; idle lanes stay zero.
    always_comb begin
        lanes_n = lanes_r;
        if (accept) begin
            lanes_n[count_r*WIDTH_P +: WIDTH_P] = data_i;
        end
    end

    always_comb begin
        fill_mask = '0;
        for (int k = 0; k < RATIO_P; k++) begin
            fill_mask[k] = (k < int'(fill));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r         <= '0;
            lanes_r         <= '0;
            flush_pending_r <= 1'b0;
            valid_o         <= 1'b0;
            data_o          <= '0;
            mask_o          <= '0;
        end else begin
            if (load) begin
                count_r <= '0;
                lanes_r <= '0;
                data_o  <= lanes_n;
                mask_o  <= fill_mask;
                valid_o <= 1'b1;
            end else begin
                lanes_r <= lanes_n;
                if (accept) begin
                    count_r <= count_r + 1'b1;
                end
                if (valid_o & ready_i) begin
                    valid_o <= 1'b0;
                end
            end
            // An empty-accumulator flush is dropped rather than left pending.
            flush_pending_r <= flush_req & ~load & (fill != '0);
        end
    end

endmodule
